map_tile_store: RTL and testbench
=================================

Name: map_tile_store

Overview:
- Tile-map storage that answers the display scanner's (map_x, map_y) → sprite_type lookups.
- Accepts tile updates from game logic over a req/ack write port.
- Provides a second read port for collision checks.
- Initialises itself to the default maze after reset and tracks the number of remaining orbs.

Parameters:
MAP_W, 21, tiles per row; valid x is 0..MAP_W-1
MAP_H, 21, tiles per column; valid y is 0..MAP_H-1
START_X, 10, player start tile x
START_Y, 9, player start tile y

Ports:
clock_50  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high; restarts initialisation
map_x  in  5  display read x
map_y  in  5  display read y
sprite_type  out  3  tile code at (map_x, map_y); combinational
q_x  in  5  game-logic query x
q_y  in  5  game-logic query y
q_type  out  3  tile code at (q_x, q_y); combinational
wr_req  in  1  write request; held high until wr_ack
wr_x  in  5  write tile x
wr_y  in  5  write tile y
wr_type  in  3  new tile code
wr_ack  out  1  one-cycle pulse; write committed at this edge
wr_err  out  1  one-cycle pulse with wr_ack when coordinates are out of range
ready  out  1  high once initialisation completes
orb_count  out  9  number of tiles currently coded 001 or 010
big_orb_eaten  out  1  one-cycle pulse when a 001 tile is overwritten with a non-001 code

Behaviour:
- Tile codes:
  - 000 black
  - 001 big orb
  - 010 small orb
  - 011 wall
  - 100 player
- Storage: MAP_W*MAP_H entries of 3 bits each.
- Reads are asynchronous on both read ports; no latency.
- A read with coordinates outside the map returns 000.
- A read of a tile being written in the same cycle returns the old value; the new value is visible from the next cycle.
- Default layout, for tile (x,y):
  - Border (x==0, x==MAP_W-1, y==0 or y==MAP_H-1): 011
  - Interior tile with x even and y even (pillar): 011
  - (1,1), (MAP_W-2,1), (1,MAP_H-2), (MAP_W-2,MAP_H-2): 001
  - (START_X,START_Y): 100
  - Every other tile: 010
  - Defaults give 4 big orbs plus 275 small orbs, so orb_count = 279.
- FSM states: INIT, IDLE, ACK.
  - Reset (any state, including mid-INIT or mid-ACK):
    - Next state INIT; init counters ix=0, iy=0.
    - ready=0, wr_ack=0, wr_err=0, big_orb_eaten=0, orb_count=0.
  - INIT:
    - Each cycle writes the layout value to (ix,iy).
    - orb_count increments by 1 when that value is 001 or 010.
    - ix increments; at ix==MAP_W-1, ix wraps to 0 and iy increments.
    - After writing (MAP_W-1, MAP_H-1), go to IDLE with ready=1.
    - Total is exactly MAP_W*MAP_H cycles (441 with defaults), then ready rises on the next edge.
    - Reads during INIT return the current storage contents; unwritten tiles are undefined and must not be relied on.
    - wr_req is ignored during INIT (no ack).
  - IDLE:
    - When wr_req=1, sample wr_x/wr_y/wr_type at this edge.
    - If in range, write the tile; otherwise raise wr_err.
    - Assert wr_ack for the next cycle; next state ACK.
    - The write and all counter updates occur on this same edge, concurrent with wr_ack rising.
  - ACK:
    - wr_ack=1 for exactly one cycle, then return to IDLE.
    - A wr_req still high in the ACK cycle is not sampled. It is treated as a new request only when seen in IDLE, so back-to-back writes occur at most one every 2 cycles.
- orb_count update on an in-range write (old = stored code):
  - old orb, new non-orb: −1
  - old non-orb, new orb: +1
  - Otherwise unchanged; this includes orb→orb, e.g. 001→010.
  - Saturates at 0 and at 511.
- big_orb_eaten:
  - Pulses with wr_ack when old==001 and new!=001 on an in-range write.
- Out-of-range write (x>=MAP_W or y>=MAP_H):
  - Storage and orb_count unchanged.
  - wr_ack and wr_err both pulse.
- ready stays 1 until the next reset.

Test Plan:
- Reset 1 cycle, then release → ready=0 for 441 cycles, then 1; orb_count=279. Reads: (0,0)=011, (2,2)=011, (1,1)=001, (10,9)=100, (3,1)=010, (25,3)=000.
- Pulse wr_req during INIT at cycle 100 → no wr_ack.
- After ready, write (3,1)←000 → wr_ack one cycle later; q_type(3,1)=000; orb_count=278; big_orb_eaten=0.
- Write (1,1)←100 → big_orb_eaten pulses with wr_ack; orb_count decrements by 1.
- Write (1,1)←010, a non-orb→orb transition → orb_count increments.
- Write (21,5)←011 → wr_ack and wr_err pulse; storage and orb_count unchanged.
- Hold wr_req high for 6 cycles → exactly 3 acks (IDLE/ACK alternation).
- Assert reset mid-INIT at cycle 200 and again during an ACK cycle → INIT restarts from (0,0); wr_ack drops; after 441 cycles orb_count=279.
- Drive map_x/map_y equal to wr_x/wr_y on the commit edge → sprite_type shows the old value that cycle and the new value the next cycle.

Source files
------------

// File: rtl/map_tile_store.sv
// map_tile_store: tile-map storage with two async read ports, a req/ack write port,
// self-initialisation to the default maze, and an orb counter.
module map_tile_store #(
    parameter int MAP_W   = 21,
    parameter int MAP_H   = 21,
    parameter int START_X = 10,
    parameter int START_Y = 9
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic [4:0] map_x,
    input  logic [4:0] map_y,
    output logic [2:0] sprite_type,
    input  logic [4:0] q_x,
    input  logic [4:0] q_y,
    output logic [2:0] q_type,
    input  logic       wr_req,
    input  logic [4:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [2:0] wr_type,
    output logic       wr_ack,
    output logic       wr_err,
    output logic       ready,
    output logic [8:0] orb_count,
    output logic       big_orb_eaten
);
    localparam int N = MAP_W * MAP_H;
    localparam int AW = $clog2(N);
    localparam logic [4:0] XMAX = 5'(MAP_W - 1);
    localparam logic [4:0] YMAX = 5'(MAP_H - 1);
    localparam logic [4:0] X1 = 5'(MAP_W - 2);
    localparam logic [4:0] Y1 = 5'(MAP_H - 2);
    localparam logic [4:0] SX = 5'(START_X);
    localparam logic [4:0] SY = 5'(START_Y);

    typedef enum logic [1:0] {INIT, IDLE, ACK} state_t;

    state_t state_q, state_d;
    logic [4:0] ix_q, ix_d, iy_q, iy_d;
    logic [8:0] orb_q, orb_d;
    logic wr_err_q, wr_err_d, boe_q, boe_d;
    logic [2:0] mem_q [N];
    logic wr_go, wr_ok, inc, dec, mem_we;
    logic [2:0] old_t, init_t, mem_wd;
    logic [AW-1:0] mem_a;

    function automatic logic in_map(input logic [4:0] x, input logic [4:0] y);
        return x <= XMAX && y <= YMAX;
    endfunction

    function automatic logic [AW-1:0] addr(input logic [4:0] x, input logic [4:0] y);
        return AW'(y) * AW'(MAP_W) + AW'(x);
    endfunction

    function automatic logic is_orb(input logic [2:0] c);
        return c == 3'b001 || c == 3'b010;
    endfunction

    function automatic logic [2:0] layout(input logic [4:0] x, input logic [4:0] y);
        logic border, pillar, corner;
        border = x == 5'd0 || x == XMAX || y == 5'd0 || y == YMAX;
        pillar = !x[0] && !y[0];
        corner = (x == 5'd1 || x == X1) && (y == 5'd1 || y == Y1);
        return (border || pillar) ? 3'b011 : corner ? 3'b001 : (x == SX && y == SY) ? 3'b100 : 3'b010;
    endfunction

    assign sprite_type = in_map(map_x, map_y) ? mem_q[addr(map_x, map_y)] : 3'b000;
    assign q_type      = in_map(q_x, q_y) ? mem_q[addr(q_x, q_y)] : 3'b000;

    assign wr_go  = state_q == IDLE && wr_req;
    assign wr_ok  = wr_go && in_map(wr_x, wr_y);
    assign old_t  = in_map(wr_x, wr_y) ? mem_q[addr(wr_x, wr_y)] : 3'b000;
    assign init_t = layout(ix_q, iy_q);

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q  <= INIT;
            ix_q     <= '0;
            iy_q     <= '0;
            orb_q    <= '0;
            wr_err_q <= 1'b0;
            boe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ix_q     <= ix_d;
            iy_q     <= iy_d;
            orb_q    <= orb_d;
            wr_err_q <= wr_err_d;
            boe_q    <= boe_d;
        end
    end

    always_ff @(posedge clock_50) begin
        if (mem_we) mem_q[mem_a] <= mem_wd;
    end

    always_comb begin
        state_d = state_q == INIT ? ((ix_q == XMAX && iy_q == YMAX) ? IDLE : INIT)
                : state_q == IDLE ? (wr_req ? ACK : IDLE) : IDLE;
        ix_d = state_q == INIT ? (ix_q == XMAX ? 5'd0 : ix_q + 5'd1) : ix_q;
        iy_d = (state_q == INIT && ix_q == XMAX) ? iy_q + 5'd1 : iy_q;
    end

    // An orb->orb rewrite (e.g. big to small) leaves the count alone.
    always_comb begin
        inc      = state_q == INIT ? is_orb(init_t) : wr_ok && !is_orb(old_t) && is_orb(wr_type);
        dec      = wr_ok && is_orb(old_t) && !is_orb(wr_type);
        orb_d    = (inc && orb_q != 9'h1ff) ? orb_q + 9'd1 : (dec && orb_q != 9'd0) ? orb_q - 9'd1 : orb_q;
        wr_err_d = wr_go && !wr_ok;
        boe_d    = wr_ok && old_t == 3'b001 && wr_type != 3'b001;
        mem_we   = !reset && (state_q == INIT || wr_ok);
        mem_a    = state_q == INIT ? addr(ix_q, iy_q) : addr(wr_x, wr_y);
        mem_wd   = state_q == INIT ? init_t : wr_type;
    end

    assign wr_ack        = state_q == ACK;
    assign ready         = state_q != INIT;
    assign wr_err        = wr_err_q;
    assign big_orb_eaten = boe_q;
    assign orb_count     = orb_q;
endmodule

// File: tb/tb_map_tile_store.sv
// tb_map_tile_store: random and directed writes against a tile-array reference model,
// with a scoreboard monitor checking every write acknowledge.
module tb_map_tile_store;
    logic clock_50 = 1'b0;
    logic reset = 1'b0;
    logic [4:0] map_x = '0, map_y = '0, q_x = '0, q_y = '0, wr_x = '0, wr_y = '0;
    logic [2:0] wr_type = '0;
    logic wr_req = 1'b0;
    logic [2:0] sprite_type, q_type;
    logic wr_ack, wr_err, ready, big_orb_eaten;
    logic [8:0] orb_count;

    int checks = 0;
    int errors = 0;

    typedef struct {bit err; bit boe; int orb;} exp_t;
    exp_t sb[$];
    logic [2:0] model [21][21];

    map_tile_store dut (
        .clock_50(clock_50), .reset(reset),
        .map_x(map_x), .map_y(map_y), .sprite_type(sprite_type),
        .q_x(q_x), .q_y(q_y), .q_type(q_type),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type),
        .wr_ack(wr_ack), .wr_err(wr_err), .ready(ready),
        .orb_count(orb_count), .big_orb_eaten(big_orb_eaten)
    );

    always #5 clock_50 = ~clock_50;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] deflt(input int x, input int y);
        if (x == 0 || x == 20 || y == 0 || y == 20 || (x % 2 == 0 && y % 2 == 0)) return 3'b011;
        if ((x == 1 || x == 19) && (y == 1 || y == 19)) return 3'b001;
        if (x == 10 && y == 9) return 3'b100;
        return 3'b010;
    endfunction

    function automatic void model_init();
        for (int x = 0; x < 21; x++)
            for (int y = 0; y < 21; y++) model[x][y] = deflt(x, y);
    endfunction

    function automatic int orbs();
        int n = 0;
        for (int x = 0; x < 21; x++)
            for (int y = 0; y < 21; y++) n += (model[x][y] == 3'b001 || model[x][y] == 3'b010) ? 1 : 0;
        return n > 511 ? 511 : n;
    endfunction

    function automatic logic [2:0] peek(input int x, input int y);
        return (x < 21 && y < 21) ? model[x][y] : 3'b000;
    endfunction

    function automatic exp_t model_write(input int x, input int y, input int t);
        exp_t e;
        bit inr = x < 21 && y < 21;
        logic [2:0] old = peek(x, y);
        e.err = !inr;
        e.boe = inr && old == 3'b001 && t != 1;
        if (inr) model[x][y] = 3'(t);
        e.orb = orbs();
        return e;
    endfunction

    // Monitor: every acknowledge must match the oldest outstanding expectation.
    always @(negedge clock_50) begin
        exp_t e;
        if (!reset) begin
            if (wr_ack) begin
                chk("ack_expected", sb.size() > 0 ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wr_err", wr_err, e.err);
                    chk("big_orb_eaten", big_orb_eaten, e.boe);
                    chk("orb_count_ack", orb_count, e.orb);
                end
            end else begin
                chk("stray_err", wr_err, 0);
                chk("stray_boe", big_orb_eaten, 0);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        wr_req = 1'b0;
        @(posedge clock_50);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_orb", orb_count, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_boe", big_orb_eaten, 0);
        reset = 1'b0;
        sb.delete();
        model_init();
    endtask

    task automatic wait_ready(input int pulse_at);
        int n = 0;
        wr_x = 5'd4;
        wr_y = 5'd3;
        wr_type = 3'd0;
        while (!ready && n < 1000) begin
            wr_req = (n == pulse_at);
            @(posedge clock_50);
            n++;
            #1;
        end
        wr_req = 1'b0;
        chk("init_cycles", n, 441);
        chk("orb_after_init", orb_count, 279);
    endtask

    task automatic check_map();
        for (int y = 0; y < 21; y++)
            for (int x = 0; x < 21; x++) begin
                map_x = 5'(x); map_y = 5'(y);
                q_x = 5'(20 - x); q_y = 5'(20 - y);
                #1;
                chk("sprite_map", sprite_type, peek(x, y));
                chk("q_map", q_type, peek(20 - x, 20 - y));
            end
    endtask

    task automatic do_write(input int x, input int y, input int t);
        int n = 0;
        sb.push_back(model_write(x, y, t));
        wr_x = 5'(x); wr_y = 5'(y); wr_type = 3'(t);
        wr_req = 1'b1;
        do begin
            @(posedge clock_50);
            #1;
            n++;
        end while (!wr_ack && n < 10);
        wr_req = 1'b0;
        chk("ack_seen", wr_ack, 1);
        q_x = 5'(x); q_y = 5'(y);
        #1;
        chk("q_after_write", q_type, peek(x, y));
        @(posedge clock_50);
        #1;
    endtask

    initial begin
        int acks;
        logic [2:0] old;
        do_reset();
        wait_ready(100);
        check_map();
        map_x = 5'd25; map_y = 5'd3; q_x = 5'd3; q_y = 5'd21;
        #1;
        chk("oob_sprite", sprite_type, 0);
        chk("oob_q", q_type, 0);
        map_x = 5'd31; map_y = 5'd31;
        #1;
        chk("oob_sprite_max", sprite_type, 0);

        do_write(3, 1, 0);
        chk("orb_278", orb_count, 278);
        do_write(1, 1, 4);
        do_write(1, 1, 2);
        do_write(21, 5, 3);
        do_write(5, 21, 0);
        chk("orb_after_oob", orb_count, orbs());

        // Same-cycle read of the tile being committed.
        old = peek(7, 5);
        map_x = 5'd7; map_y = 5'd5;
        sb.push_back(model_write(7, 5, 3));
        wr_x = 5'd7; wr_y = 5'd5; wr_type = 3'd3; wr_req = 1'b1;
        @(negedge clock_50);
        chk("same_cycle_old", sprite_type, old);
        @(posedge clock_50);
        #1;
        wr_req = 1'b0;
        chk("same_cycle_ack", wr_ack, 1);
        chk("same_cycle_new", sprite_type, 3);
        @(posedge clock_50);
        #1;

        // Held request: one acknowledge every two cycles.
        for (int i = 0; i < 3; i++) sb.push_back(model_write(3, 3, 0));
        wr_x = 5'd3; wr_y = 5'd3; wr_type = 3'd0; wr_req = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clock_50);
            #1;
            acks += int'(wr_ack);
        end
        wr_req = 1'b0;
        chk("hold_acks", acks, 3);
        @(posedge clock_50);
        #1;

        repeat (40) do_write(int'($urandom_range(0, 23)), int'($urandom_range(0, 23)), int'($urandom_range(0, 7)));
        check_map();

        // Reset in the middle of initialisation.
        do_reset();
        repeat (200) @(posedge clock_50);
        #1;
        do_reset();
        wait_ready(-1);
        check_map();

        // Reset during an acknowledge cycle.
        do_write(19, 19, 0);
        wr_x = 5'd5; wr_y = 5'd5; wr_type = 3'd0; wr_req = 1'b1;
        @(posedge clock_50);
        #1;
        chk("ack_before_reset", wr_ack, 1);
        do_reset();
        wait_ready(-1);
        q_x = 5'd5; q_y = 5'd5; map_x = 5'd19; map_y = 5'd19;
        #1;
        chk("reinit_5_5", q_type, 2);
        chk("reinit_19_19", sprite_type, 1);

        repeat (3) @(posedge clock_50);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
